// File: rtl/sha_const.sv
// Shared constants for the SHA block sequencer: state encoding, default block
// geometry and counter widths.
package sha_const;

  localparam int BLK_BYTES_DEF = 64;
  localparam int LEN_BYTES_DEF = 8;
  localparam int BLK_CNT_W     = 16;
  // Wide enough that Length + 1 + LEN_BYTES cannot overflow for a 32-bit Length.
  localparam int CALC_W        = 33;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALC      = 3'd1,
    LOAD      = 3'd2,
    WAIT_BLK  = 3'd3,
    HASH      = 3'd4,
    WAIT_CORE = 3'd5,
    FINISH    = 3'd6
  } sha_state_e;

endpackage

// File: rtl/sha_ctrl.sv
// SHA message sequencer: works out how many padded blocks a message needs,
// then alternates between the padding block and the compression core until
// the last block is hashed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Start; Length captured on acceptance
// CALC      | block count for the captured length is computed
// LOAD      | one-cycle Blk_Enable request to the padding block
// WAIT_BLK  | waiting for Blk_Ready from the padding block
// HASH      | one-cycle Core_Start with Core_First / Last qualifiers
// WAIT_CORE | waiting for Core_Done; next block or finish
// FINISH    | one-cycle Done pulse, back to IDLE
//
// All outputs are registered: each one is decoded from the next state so it
// is high exactly while the FSM sits in the corresponding state.
module sha_ctrl
  import sha_const::*;
#(
  parameter int BLK_BYTES = BLK_BYTES_DEF,
  parameter int LEN_BYTES = LEN_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [31:0]          Length,
  input  logic                 Abort,
  input  logic                 Blk_Ready,
  input  logic                 Core_Done,
  output logic                 Blk_Enable,
  output logic                 Blk_Function,
  output logic                 Core_Start,
  output logic                 Core_First,
  output logic                 Last,
  output logic                 Busy,
  output logic                 Done,
  output logic [BLK_CNT_W-1:0] Block_Count
);

  sha_state_e            r_state;
  sha_state_e            w_next;
  logic [31:0]           r_length;
  logic [CALC_W-1:0]     r_nblk;
  logic [BLK_CNT_W-1:0]  r_block_count;

  logic [CALC_W-1:0]     w_total;
  logic [CALC_W-1:0]     w_quot;
  logic [CALC_W-1:0]     w_rem;
  logic [CALC_W-1:0]     w_nblk;
  logic [CALC_W-1:0]     w_count_ext;
  logic                  w_last_issue;
  logic                  w_all_issued;

  logic                  w_blk_enable;
  logic                  w_blk_function;
  logic                  w_core_start;
  logic                  w_core_first;
  logic                  w_last;
  logic                  w_done;

  // Message bytes plus the 0x80 pad byte plus the length field, rounded up to
  // whole blocks.
  assign w_total = {1'b0, r_length} + CALC_W'(1 + LEN_BYTES);
  assign w_quot  = w_total / CALC_W'(BLK_BYTES);
  assign w_rem   = w_total % CALC_W'(BLK_BYTES);
  assign w_nblk  = w_quot + {{(CALC_W-1){1'b0}}, (w_rem != '0)};

  assign w_count_ext  = {{(CALC_W-BLK_CNT_W){1'b0}}, r_block_count};
  // Block about to be issued is the final one.
  assign w_last_issue = ((w_count_ext + CALC_W'(1)) == r_nblk);
  // Count already includes the block the core just finished.
  assign w_all_issued = (w_count_ext == r_nblk);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and next-cycle output values.
  always_comb begin
    w_next         = r_state;
    w_blk_enable   = 1'b0;
    w_blk_function = 1'b0;
    w_core_start   = 1'b0;
    w_core_first   = 1'b0;
    w_last         = 1'b0;
    w_done         = 1'b0;

    case (r_state)
      IDLE:      if (Start) w_next = CALC;
      CALC:      w_next = LOAD;
      LOAD:      w_next = WAIT_BLK;
      WAIT_BLK:  if (Blk_Ready) w_next = HASH;
      HASH:      w_next = WAIT_CORE;
      WAIT_CORE: if (Core_Done) w_next = w_all_issued ? FINISH : LOAD;
      FINISH:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase

    // Abort wins over any handshake seen in the same cycle.
    if (Abort && (r_state != IDLE)) w_next = IDLE;

    case (w_next)
      LOAD: begin
        w_blk_enable   = 1'b1;
        w_blk_function = (r_block_count != '0);
      end
      HASH: begin
        w_core_start = 1'b1;
        w_core_first = (r_block_count == '0);
        w_last       = w_last_issue;
      end
      FINISH:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Message length, block total and issued-block counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_length      <= '0;
      r_nblk        <= '0;
      r_block_count <= '0;
    end else begin
      if ((r_state == IDLE) && Start) begin
        r_length      <= Length;
        r_block_count <= '0;
      end
      if (r_state == CALC) r_nblk <= w_nblk;
      if (w_core_start) r_block_count <= r_block_count + BLK_CNT_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Blk_Enable   <= 1'b0;
      Blk_Function <= 1'b0;
      Core_Start   <= 1'b0;
      Core_First   <= 1'b0;
      Last         <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Blk_Enable   <= w_blk_enable;
      Blk_Function <= w_blk_function;
      Core_Start   <= w_core_start;
      Core_First   <= w_core_first;
      Last         <= w_last;
      Busy         <= (w_next != IDLE);
      Done         <= w_done;
    end
  end

  assign Block_Count = r_block_count;

endmodule

// File: tb/tb_sha_ctrl.sv
// Bench for sha_ctrl: a 64/8 instance and a 128/16 instance, auto-responding
// padding/core models, per-message event monitors and a block-count model.
module tb_sha_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, abort;
  logic [31:0] length;
  logic        rdy_auto_a, rdy_man_a, cd_auto_a, cd_man_a;
  logic        rdy_auto_b, cd_auto_b;
  logic        rdy_a, cd_a;
  bit          auto_a;

  assign rdy_a = rdy_auto_a | rdy_man_a;
  assign cd_a  = cd_auto_a  | cd_man_a;

  logic        be_a, bf_a, cs_a, cf_a, last_a, busy_a, done_a;
  logic [15:0] bc_a;
  logic        be_b, bf_b, cs_b, cf_b, last_b, busy_b, done_b;
  logic [15:0] bc_b;

  sha_ctrl dut_a (
    .clk(clk), .rst(rst), .Start(start_a), .Length(length), .Abort(abort),
    .Blk_Ready(rdy_a), .Core_Done(cd_a),
    .Blk_Enable(be_a), .Blk_Function(bf_a), .Core_Start(cs_a),
    .Core_First(cf_a), .Last(last_a), .Busy(busy_a), .Done(done_a),
    .Block_Count(bc_a)
  );

  sha_ctrl #(.BLK_BYTES(128), .LEN_BYTES(16)) dut_b (
    .clk(clk), .rst(rst), .Start(start_b), .Length(length), .Abort(1'b0),
    .Blk_Ready(rdy_auto_b), .Core_Done(cd_auto_b),
    .Blk_Enable(be_b), .Blk_Function(bf_b), .Core_Start(cs_b),
    .Core_First(cf_b), .Last(last_b), .Busy(busy_b), .Done(done_b),
    .Block_Count(bc_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responders: answer a request after a random 1..4 cycle delay.
  int rc_a = 0, cc_a = 0, rc_b = 0, cc_b = 0;
  always @(negedge clk) begin
    rdy_auto_a = 1'b0;
    cd_auto_a  = 1'b0;
    if (!auto_a) begin
      rc_a = 0;
      cc_a = 0;
    end else begin
      if (rc_a > 0) begin rc_a--; if (rc_a == 0) rdy_auto_a = 1'b1; end
      if (cc_a > 0) begin cc_a--; if (cc_a == 0) cd_auto_a = 1'b1; end
      if (be_a) rc_a = int'($urandom_range(1, 4));
      if (cs_a) cc_a = int'($urandom_range(1, 4));
    end
  end

  always @(negedge clk) begin
    rdy_auto_b = 1'b0;
    cd_auto_b  = 1'b0;
    if (rc_b > 0) begin rc_b--; if (rc_b == 0) rdy_auto_b = 1'b1; end
    if (cc_b > 0) begin cc_b--; if (cc_b == 0) cd_auto_b = 1'b1; end
    if (be_b) rc_b = int'($urandom_range(1, 4));
    if (cs_b) cc_b = int'($urandom_range(1, 4));
  end

  // Monitors: record the request/start/done events of the current message.
  bit       bfq_a[$];
  bit [1:0] csq_a[$];
  int       dn_a = 0, vio_a = 0;
  bit       pbe_a = 0, pcs_a = 0, pdn_a = 0;
  bit       bfq_b[$];
  bit [1:0] csq_b[$];
  int       dn_b = 0, vio_b = 0;
  bit       pbe_b = 0, pcs_b = 0, pdn_b = 0;

  always @(negedge clk) begin
    if (be_a) bfq_a.push_back(bf_a);
    if (cs_a) csq_a.push_back({cf_a, last_a});
    if (done_a) dn_a++;
    if ((be_a && pbe_a) || (cs_a && pcs_a) || (done_a && pdn_a)) vio_a++;
    pbe_a = be_a; pcs_a = cs_a; pdn_a = done_a;
  end

  always @(negedge clk) begin
    if (be_b) bfq_b.push_back(bf_b);
    if (cs_b) csq_b.push_back({cf_b, last_b});
    if (done_b) dn_b++;
    if ((be_b && pbe_b) || (cs_b && pcs_b) || (done_b && pdn_b)) vio_b++;
    pbe_b = be_b; pcs_b = cs_b; pdn_b = done_b;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bfq_a.delete(); csq_a.delete(); dn_a = 0; vio_a = 0;
    bfq_b.delete(); csq_b.delete(); dn_b = 0; vio_b = 0;
  endtask

  // Reference: a message needs ceil((len + 1 + lenb) / blk) blocks; block i
  // is a continuation unless i==0, first only at i==0, last at i==n-1.
  task automatic check_msg(input string tag, input longint len, input int blk, input int lenb,
                           input bit bfq[$], input bit [1:0] csq[$], input int dn,
                           input int vio, input logic [15:0] bc);
    longint n;
    n = (len + 1 + lenb + blk - 1) / blk;
    check({tag, " enables"}, bfq.size(), n);
    check({tag, " starts"}, csq.size(), n);
    for (int i = 0; i < bfq.size() && i < n; i++)
      check($sformatf("%s blk_function[%0d]", tag, i), bfq[i], (i != 0));
    for (int i = 0; i < csq.size() && i < n; i++)
      check($sformatf("%s first/last[%0d]", tag, i), csq[i], {(i == 0), (i == n - 1)});
    check({tag, " done pulses"}, dn, 1);
    check({tag, " back-to-back pulses"}, vio, 0);
    check({tag, " block_count"}, bc, n);
  endtask

  task automatic run_msg(input string tag, input logic [31:0] len, input bit use_b);
    clear_mon();
    length  = len;
    start_a = 1'b1;
    start_b = use_b;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 0; c < 3000 && !(dn_a > 0 && (!use_b || dn_b > 0)); c++) tick();
    tick();
    check({tag, " A busy after"}, busy_a, 1'b0);
    check_msg({tag, " A"}, longint'(len), 64, 8, bfq_a, csq_a, dn_a, vio_a, bc_a);
    if (use_b) begin
      check({tag, " B busy after"}, busy_b, 1'b0);
      check_msg({tag, " B"}, longint'(len), 128, 16, bfq_b, csq_b, dn_b, vio_b, bc_b);
    end
  endtask

  // which: 0 = Blk_Enable, 1 = Core_Start, 2 = Done (instance A)
  task automatic wait_a(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      seen = (which == 0) ? be_a : (which == 1) ? cs_a : done_a;
      if (seen) break;
      tick();
    end
    check({tag, " wait"}, seen, 1'b1);
  endtask

  task automatic pulse_start_a(input logic [31:0] len);
    length  = len;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; length = '0;
    rdy_man_a = 1'b0; cd_man_a = 1'b0; auto_a = 1'b1;
    tick();
    check("reset outputs A", {be_a, bf_a, cs_a, cf_a, last_a, busy_a, done_a}, 7'd0);
    check("reset count A", bc_a, 16'd0);
    check("reset outputs B", {be_b, bf_b, cs_b, cf_b, last_b, busy_b, done_b}, 7'd0);
    tick();
    rst = 1'b1;
    tick();

    // Block-boundary lengths on both geometries.
    run_msg("len0", 32'd0, 1'b1);
    run_msg("len55", 32'd55, 1'b1);
    run_msg("len56", 32'd56, 1'b1);
    run_msg("len111", 32'd111, 1'b1);
    run_msg("len112", 32'd112, 1'b1);
    run_msg("len119", 32'd119, 1'b1);
    run_msg("len120", 32'd120, 1'b1);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] len;
      len = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3000))
                                         : 32'($urandom_range(0, 260));
      run_msg($sformatf("rand%0d len%0d", k, len), len, 1'b1);
    end

    // Start held for a whole 2-block message, and still high through FINISH.
    clear_mon();
    length  = 32'd56;
    start_a = 1'b1;
    for (int c = 0; c < 500 && dn_a == 0; c++) tick();
    tick();
    check("held idle busy", busy_a, 1'b0);
    check("held count kept", bc_a, 16'd2);
    check_msg("held", 56, 64, 8, bfq_a, csq_a, dn_a, vio_a, bc_a);
    tick();
    check("restart busy", busy_a, 1'b1);
    check("restart count cleared", bc_a, 16'd0);
    start_a = 1'b0;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in calc busy", busy_a, 1'b0);
    tick();
    check("abort in calc no enable", bfq_a.size(), 2);

    // Spurious handshakes in the wrong wait state.
    auto_a = 1'b0;
    tick();
    clear_mon();
    pulse_start_a(32'd0);
    wait_a(0, "spur load");
    tick();
    cd_man_a = 1'b1;
    tick();
    cd_man_a = 1'b0;
    tick();
    check("spur core_done ignored", csq_a.size(), 0);
    check("spur core_done busy", busy_a, 1'b1);
    rdy_man_a = 1'b1;
    tick();
    rdy_man_a = 1'b0;
    check("spur core_start", cs_a, 1'b1);
    tick();
    rdy_man_a = 1'b1;
    tick();
    rdy_man_a = 1'b0;
    tick();
    check("spur blk_ready ignored", bfq_a.size(), 1);
    check("spur blk_ready no done", dn_a, 0);
    cd_man_a = 1'b1;
    tick();
    cd_man_a = 1'b0;
    tick();
    check_msg("spur", 0, 64, 8, bfq_a, csq_a, dn_a, vio_a, bc_a);

    // Abort together with Core_Done in WAIT_CORE.
    clear_mon();
    pulse_start_a(32'd56);
    wait_a(0, "abort load");
    tick();
    rdy_man_a = 1'b1;
    tick();
    rdy_man_a = 1'b0;
    tick();
    abort    = 1'b1;
    cd_man_a = 1'b1;
    tick();
    abort    = 1'b0;
    cd_man_a = 1'b0;
    check("abort busy", busy_a, 1'b0);
    check("abort no reload", be_a, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    check("abort no done", dn_a, 0);
    check("abort single enable", bfq_a.size(), 1);

    // Asynchronous reset while waiting on the second block.
    clear_mon();
    pulse_start_a(32'd56);
    wait_a(0, "rst load");
    tick();
    rdy_man_a = 1'b1;
    tick();
    rdy_man_a = 1'b0;
    tick();
    cd_man_a = 1'b1;
    tick();
    cd_man_a = 1'b0;
    tick();
    check("pre-reset count", bc_a, 16'd1);
    rst = 1'b0;
    #1;
    check("async reset outputs", {be_a, bf_a, cs_a, cf_a, last_a, busy_a, done_a}, 7'd0);
    check("async reset count", bc_a, 16'd0);
    tick();
    tick();
    rst = 1'b1;
    clear_mon();
    for (int c = 0; c < 6; c++) tick();
    check("post-reset no done", dn_a, 0);
    check("post-reset idle", busy_a, 1'b0);
    auto_a = 1'b1;
    tick();
    run_msg("after reset", 32'd56, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
